// File: rtl/alu_divider.sv
// alu_divider: multi-cycle unsigned restoring divider, one quotient bit per clock, tristate bus result
module alu_divider #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] Lhs,
   input  logic [DATA_WIDTH-1:0] Rhs,
   input  logic                  resultSelect,
   input  logic                  aluAssert,
   output logic                  busy,
   output logic                  done,
   output logic                  divByZero,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic [DATA_WIDTH-1:0] mainBusOut
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [W-1:0] dvd, dvs, rem, rem_nxt;
   logic [W:0] rem_sh;
   logic [CW-1:0] count;
   logic ge, last;
   always_comb begin
      rem_sh = {rem, dvd[W-1]};
      ge = rem_sh >= {1'b0, dvs};
      rem_nxt = ge ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];
      last = count == CW'(1);
      state_nxt = state == RUN ? (last ? DONE : RUN) : (start ? (Rhs != '0 ? RUN : DONE) : IDLE);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;
   // dvd doubles as the quotient accumulator: dividend bits shift out the top as quotient bits enter the bottom
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         dvd <= '0;
         dvs <= '0;
         rem <= '0;
         count <= '0;
         quotient <= '0;
         remainder <= '0;
         divByZero <= 1'b0;
      end else if (state != RUN && start) begin
         if (Rhs != '0) begin
            dvd <= Lhs;
            dvs <= Rhs;
            rem <= '0;
            count <= CW'(W);
         end else begin
            quotient <= '1;
            remainder <= Lhs;
            divByZero <= 1'b1;
         end
      end else if (state == RUN) begin
         rem <= rem_nxt;
         dvd <= {dvd[W-2:0], ge};
         count <= count - CW'(1);
         if (last) begin
            quotient <= {dvd[W-2:0], ge};
            remainder <= rem_nxt;
            divByZero <= 1'b0;
         end
      end
   assign busy = state == RUN;
   assign done = state == DONE;
   assign mainBusOut = aluAssert ? (resultSelect ? remainder : quotient) : 'z;
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed vectors with hand-computed results for alu_divider
module tb_alu_divider;
   logic clk = 0, reset_n = 0, start = 0, resultSelect = 0, aluAssert = 0;
   logic [15:0] Lhs = 0, Rhs = 0;
   logic busy, done, divByZero;
   logic [15:0] quotient, remainder, mainBusOut;
   int errors = 0, checks = 0;
   int bc;
   bit got_done, bus_stable;
   logic [15:0] zz;

   alu_divider #(.DATA_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .Lhs(Lhs), .Rhs(Rhs),
      .resultSelect(resultSelect), .aluAssert(aluAssert), .busy(busy), .done(done),
      .divByZero(divByZero), .quotient(quotient), .remainder(remainder), .mainBusOut(mainBusOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // called #1 after an edge; that next edge is edge 0; returns in the done cycle
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int inj,
                         output int busy_cycles, output bit saw_done, output bit stable);
      logic [15:0] bus0;
      bus0 = mainBusOut;
      Lhs = a; Rhs = b; start = 1;
      @(posedge clk); #1;
      start = 0; Lhs = 16'hdead; Rhs = 16'h0;
      busy_cycles = 0; saw_done = 0; stable = 1;
      for (int e = 0; e < 40; e++) begin
         if (done) begin saw_done = 1; break; end
         if (busy) busy_cycles++;
         if (mainBusOut !== bus0) stable = 0;
         if (e + 1 == inj) begin start = 1; Lhs = 50; Rhs = 5; end
         else start = 0;
         @(posedge clk); #1;
      end
      start = 0;
      if (!saw_done) check("timeout", 0, 1);
   endtask

   initial begin
      zz = 'z;
      #12;
      check("rst_busy", busy, 0);
      check("rst_q", quotient, 0);
      check("rst_dbz", divByZero, 0);
      reset_n = 1;
      @(posedge clk); #1;

      run_op(100, 7, -1, bc, got_done, bus_stable);
      check("100/7 busy", bc, 16);
      check("100/7 q", quotient, 14);
      check("100/7 r", remainder, 2);
      check("100/7 dbz", divByZero, 0);
      @(posedge clk); #1;
      check("100/7 done once", done, 0);

      aluAssert = 0; #1;
      check("bus z", {16'h0, mainBusOut}, {16'h0, zz});
      aluAssert = 1; resultSelect = 0; #1;
      check("bus q", mainBusOut, 14);
      resultSelect = 1; #1;
      check("bus r", mainBusOut, 2);
      run_op(20, 6, -1, bc, got_done, bus_stable);
      check("bus stable in run", bus_stable, 1);
      check("20/6 q", quotient, 3);
      check("bus new r", mainBusOut, 2);
      aluAssert = 0;

      run_op(16'hffff, 1, -1, bc, got_done, bus_stable);
      check("ffff/1 q", quotient, 16'hffff);
      check("ffff/1 r", remainder, 0);
      run_op(3, 10, -1, bc, got_done, bus_stable);
      check("b2b busy", bc, 16);
      check("3/10 q", quotient, 0);
      check("3/10 r", remainder, 3);
      @(posedge clk); #1;

      run_op(5, 0, -1, bc, got_done, bus_stable);
      check("5/0 busy", bc, 0);
      check("5/0 q", quotient, 16'hffff);
      check("5/0 r", remainder, 5);
      check("5/0 dbz", divByZero, 1);
      @(posedge clk); #1;
      run_op(9, 3, -1, bc, got_done, bus_stable);
      check("9/3 q", quotient, 3);
      check("9/3 r", remainder, 0);
      check("9/3 dbz", divByZero, 0);
      @(posedge clk); #1;

      run_op(1000, 9, 4, bc, got_done, bus_stable);
      check("ign busy", bc, 16);
      check("ign q", quotient, 111);
      check("ign r", remainder, 1);
      @(posedge clk); #1;

      Lhs = 1000; Rhs = 9; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (6) @(posedge clk);
      #1;
      check("pre-rst busy", busy, 1);
      @(posedge clk); #1;
      reset_n = 0; #1;
      check("arst busy", busy, 0);
      check("arst q", quotient, 0);
      check("arst r", remainder, 0);
      got_done = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) got_done = 1;
      end
      check("arst no done", got_done, 0);
      reset_n = 1;
      @(posedge clk); #1;
      run_op(20, 6, -1, bc, got_done, bus_stable);
      check("20/6 q", quotient, 3);
      check("20/6 r", remainder, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
